// File: rtl/writeback_if.sv
// -----------------------------------------------------------------------------
// writeback_if
// Handshake bundle between the memory stage and the writeback stage.
//
// Signals:
//   valid_mem         memory stage presents an instruction
//   ready_mem         writeback can accept (low while a load is outstanding)
//   instr_mem         instruction word (rd=[11:7], funct3=[14:12])
//   pc_mem            instruction PC
//   alu_mem           ALU result / load byte address
//   wb_sel_mem        writeback source: 00 ALU, 01 load, 10 PC+4, 11 ALU
//   reg_write_en_mem  instruction writes rd
//
// Modports:
//   master  memory-stage side (drives the instruction, observes ready)
//   slave   writeback side (consumes the instruction, drives ready)
// -----------------------------------------------------------------------------
interface writeback_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_mem;
    logic                  ready_mem;
    logic [DATA_WIDTH-1:0] instr_mem;
    logic [DATA_WIDTH-1:0] pc_mem;
    logic [DATA_WIDTH-1:0] alu_mem;
    logic [1:0]            wb_sel_mem;
    logic                  reg_write_en_mem;

    modport master (
        output valid_mem, instr_mem, pc_mem, alu_mem, wb_sel_mem, reg_write_en_mem,
        input  ready_mem
    );

    modport slave (
        input  valid_mem, instr_mem, pc_mem, alu_mem, wb_sel_mem, reg_write_en_mem,
        output ready_mem
    );
endinterface

// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback
// Final pipeline stage: accepts retiring instructions from the memory stage,
// waits for load data when needed, formats it, and drives a registered
// one-cycle register-file write pulse plus a retired-instruction counter.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   mem               memory-stage handshake (writeback_if.slave)
//   dmem_rvalid       load response valid (only looked at in WAIT_LOAD)
//   dmem_rdata        aligned load word
//   reg_write_en      register-file write enable (one-cycle pulse)
//   instr_wb          retiring instruction (regfile takes rd from [11:7])
//   mem_wb            write data
//   rd_wb             destination index, for forwarding
//   retire            one-cycle pulse per retired instruction
//   instret           retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    writeback_if.slave            mem,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  reg_write_en,
    output logic [DATA_WIDTH-1:0] instr_wb,
    output logic [DATA_WIDTH-1:0] mem_wb,
    output logic [ADDR_WIDTH-1:0] rd_wb,
    output logic                  retire,
    output logic [CNT_WIDTH-1:0]  instret
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    state_t state, state_next;

    // Load context captured at accept time, consumed when the response arrives.
    logic [DATA_WIDTH-1:0] load_instr;
    logic [1:0]            load_off;
    logic                  load_we;

    logic                  accept;
    logic                  is_load;
    logic                  commit;
    logic [DATA_WIDTH-1:0] commit_instr;
    logic [DATA_WIDTH-1:0] commit_data;
    logic                  commit_we;

    // Byte/halfword extraction with sign or zero extension; unknown funct3
    // encodings fall back to a full-word load.
    function automatic logic [DATA_WIDTH-1:0] format_load(
        input logic [2:0]            funct3,
        input logic [1:0]            off,
        input logic [DATA_WIDTH-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (funct3)
            3'b000:  format_load = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b100:  format_load = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b001:  format_load = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b101:  format_load = {{(DATA_WIDTH-16){1'b0}}, h};
            default: format_load = word;
        endcase
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept && is_load) state_next = WAIT_LOAD;
            WAIT_LOAD: if (dmem_rvalid)       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    assign is_load = (mem.wb_sel_mem == SEL_LOAD);

    always_comb begin
        mem.ready_mem = (state == IDLE);
        accept        = mem.valid_mem && (state == IDLE);
        commit        = 1'b0;
        commit_instr  = mem.instr_mem;
        commit_we     = mem.reg_write_en_mem;
        commit_data   = mem.alu_mem;
        case (state)
            IDLE: begin
                commit = accept && !is_load;
                if (mem.wb_sel_mem == SEL_PC4)
                    commit_data = mem.pc_mem + DATA_WIDTH'(4);
            end
            WAIT_LOAD: begin
                commit       = dmem_rvalid;
                commit_instr = load_instr;
                commit_we    = load_we;
                commit_data  = format_load(load_instr[14:12], load_off, dmem_rdata);
            end
            default: ;
        endcase
    end

    // NOTE: the load-context registers carry no reset; they are only read in
    // WAIT_LOAD, which is always entered through a capture.
    always_ff @(posedge clk) begin
        if (accept && is_load) begin
            load_instr <= mem.instr_mem;
            load_off   <= mem.alu_mem[1:0];
            load_we    <= mem.reg_write_en_mem;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_en <= 1'b0;
            retire       <= 1'b0;
            instr_wb     <= '0;
            mem_wb       <= '0;
            rd_wb        <= '0;
            instret      <= '0;
        end else begin
            // Writes to x0 still retire but never reach the register file.
            reg_write_en <= commit && commit_we && (commit_instr[11:7] != 5'd0);
            retire       <= commit;
            if (commit) begin
                instr_wb <= commit_instr;
                mem_wb   <= commit_data;
                rd_wb    <= commit_instr[7 +: ADDR_WIDTH];
                instret  <= instret + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback.sv
// -----------------------------------------------------------------------------
// tb_writeback
// Scoreboard bench for writeback: the driver pushes the expected commit when
// it issues an instruction (or its load response); a monitor pops and compares
// on every retire pulse.
// -----------------------------------------------------------------------------
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        reg_write_en;
    logic [31:0] instr_wb;
    logic [31:0] mem_wb;
    logic [4:0]  rd_wb;
    logic        retire;
    logic [63:0] instret;

    always #5 clk = ~clk;

    writeback_if #(.DATA_WIDTH(32)) mif ();

    writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (mif),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .reg_write_en (reg_write_en),
        .instr_wb     (instr_wb),
        .mem_wb       (mem_wb),
        .rd_wb        (rd_wb),
        .retire       (retire),
        .instret      (instret)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] data;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] exp_cnt = '0;

    function automatic logic [31:0] mk_instr(input logic [16:0] hi, input logic [2:0] f3,
                                             input logic [4:0] rd, input logic [6:0] op);
        return {hi, f3, rd, op};
    endfunction

    // Reference load formatting from plain shifts, masks and arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] byte_v, half_v;
        byte_v = (word >> (8 * addr[1:0])) & 32'hFF;
        half_v = (word >> (16 * addr[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (byte_v >= 128) ? byte_v + 32'hFFFF_FF00 : byte_v;
            3'd4:    return byte_v;
            3'd1:    return (half_v >= 32768) ? half_v + 32'hFFFF_0000 : half_v;
            3'd5:    return half_v;
            default: return word;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (retire) begin
                if (sb.size() == 0) begin
                    check("retire_without_issue", {63'd0, retire}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    exp_cnt = exp_cnt + 1;
                    check("instr_wb", {32'd0, instr_wb}, {32'd0, e.instr});
                    check("mem_wb", {32'd0, mem_wb}, {32'd0, e.data});
                    check("rd_wb", {59'd0, rd_wb}, {59'd0, e.instr[11:7]});
                    check("reg_write_en", {63'd0, reg_write_en}, {63'd0, e.we});
                    check("instret", instret, exp_cnt);
                end
            end else begin
                check("we_without_retire", {63'd0, reg_write_en}, 64'd0);
            end
        end
    end

    // Reset discards everything in flight.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            exp_cnt = '0;
        end
    end

    // ---------------- driver ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mif.valid_mem = 1'b0;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        mif.valid_mem = 1'b0;
    endtask

    // Leaves valid_mem high after an ALU-type accept so consecutive calls run
    // back-to-back; call idle() to end a burst. Loads wait wait_cyc cycles
    // (rvalid in the last one) and return in the cycle after rvalid.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [1:0] sel, input logic we, input logic [31:0] rdata,
                         input int wait_cyc);
        exp_t e;
        @(negedge clk);
        check("ready_at_issue", {63'd0, mif.ready_mem}, 64'd1);
        mif.valid_mem        = 1'b1;
        mif.instr_mem        = instr;
        mif.pc_mem           = pc;
        mif.alu_mem          = alu;
        mif.wb_sel_mem       = sel;
        mif.reg_write_en_mem = we;
        e.instr = instr;
        e.we    = we && (instr[11:7] != 5'd0);
        if (sel != 2'b01) begin
            e.data = (sel == 2'b10) ? pc + 32'd4 : alu;
            sb.push_back(e);
            @(posedge clk);
        end else begin
            @(posedge clk);
            for (int i = 0; i < wait_cyc; i++) begin
                @(negedge clk);
                mif.valid_mem = 1'b0;
                check("ready_low_in_load", {63'd0, mif.ready_mem}, 64'd0);
                if (i == wait_cyc - 1) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                    e.data = ref_load(instr[14:12], alu, rdata);
                    sb.push_back(e);
                end else begin
                    dmem_rvalid = 1'b0;
                    dmem_rdata  = $urandom;
                end
                @(posedge clk);
            end
            @(negedge clk);
            dmem_rvalid = 1'b0;
            check("ready_after_rvalid", {63'd0, mif.ready_mem}, 64'd1);
        end
    endtask

    localparam logic [6:0] OP_ALU  = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    initial begin
        rst                  = 1'b1;
        dmem_rvalid          = 1'b0;
        dmem_rdata           = '0;
        mif.valid_mem        = 1'b0;
        mif.instr_mem        = '0;
        mif.pc_mem           = '0;
        mif.alu_mem          = '0;
        mif.wb_sel_mem       = 2'b00;
        mif.reg_write_en_mem = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_reg_write_en", {63'd0, reg_write_en}, 64'd0);
        check("rst_retire", {63'd0, retire}, 64'd0);
        check("rst_instr_wb", {32'd0, instr_wb}, 64'd0);
        check("rst_mem_wb", {32'd0, mem_wb}, 64'd0);
        check("rst_rd_wb", {59'd0, rd_wb}, 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_ready", {63'd0, mif.ready_mem}, 64'd1);

        // ADD x5.
        issue(mk_instr(17'h0, 3'd0, 5'd5, OP_ALU), 32'h100, 32'h0000_1234, 2'b00, 1'b1, 32'h0, 0);
        idle();
        check("add_we", {63'd0, reg_write_en}, 64'd1);
        check("add_rd", {59'd0, instr_wb[11:7]}, 64'd5);
        check("add_data", {32'd0, mem_wb}, 64'h0000_1234);
        check("add_instret", instret, 64'd1);

        // Loads with rvalid two cycles after accept.
        issue(mk_instr(17'h0, 3'd0, 5'd6, OP_LOAD), 32'h104, 32'h0000_0003, 2'b01, 1'b1, 32'h80AA_BBCC, 2);
        check("lb_data", {32'd0, mem_wb}, 64'hFFFF_FF80);
        check("lb_rd", {59'd0, rd_wb}, 64'd6);
        issue(mk_instr(17'h0, 3'd4, 5'd6, OP_LOAD), 32'h108, 32'h0000_0003, 2'b01, 1'b1, 32'h80AA_BBCC, 2);
        check("lbu_data", {32'd0, mem_wb}, 64'h0000_0080);
        issue(mk_instr(17'h0, 3'd5, 5'd6, OP_LOAD), 32'h10C, 32'h0000_0002, 2'b01, 1'b1, 32'h80AA_BBCC, 2);
        check("lhu_data", {32'd0, mem_wb}, 64'h0000_80AA);
        issue(mk_instr(17'h0, 3'd1, 5'd6, OP_LOAD), 32'h110, 32'h0000_0000, 2'b01, 1'b1, 32'h80AA_BBCC, 2);
        check("lh_data", {32'd0, mem_wb}, 64'hFFFF_BBCC);

        // JAL x1 with PC+4 wrapping.
        issue(mk_instr(17'h0, 3'd0, 5'd1, OP_JAL), 32'hFFFF_FFFC, 32'h0, 2'b10, 1'b1, 32'h0, 0);
        idle();
        check("jal_data", {32'd0, mem_wb}, 64'h0);
        check("jal_we", {63'd0, reg_write_en}, 64'd1);

        // Write to x0: retires, no write.
        issue(mk_instr(17'h0, 3'd0, 5'd0, OP_ALU), 32'h200, 32'hDEAD_BEEF, 2'b00, 1'b1, 32'h0, 0);
        idle();
        check("x0_we", {63'd0, reg_write_en}, 64'd0);
        check("x0_retire", {63'd0, retire}, 64'd1);
        check("x0_instret", instret, 64'd7);

        // Three back-to-back ALU ops with a stray rvalid held high.
        do_reset();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        for (int i = 0; i < 3; i++)
            issue(mk_instr(17'h1, 3'd0, 5'(i + 10), OP_ALU), 32'h300, 32'(i * 7 + 1), 2'b11, 1'b1, 32'h0, 0);
        idle();
        dmem_rvalid = 1'b0;
        check("b2b_instret", instret, 64'd3);
        check("b2b_we", {63'd0, reg_write_en}, 64'd1);
        check("b2b_ready", {63'd0, mif.ready_mem}, 64'd1);

        // Reset while a load is outstanding discards it.
        @(negedge clk);
        mif.valid_mem        = 1'b1;
        mif.instr_mem        = mk_instr(17'h0, 3'd2, 5'd9, OP_LOAD);
        mif.alu_mem          = 32'h40;
        mif.wb_sel_mem       = 2'b01;
        mif.reg_write_en_mem = 1'b1;
        @(negedge clk);
        mif.valid_mem = 1'b0;
        check("rl_ready_low", {63'd0, mif.ready_mem}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rl_ready_after_rst", {63'd0, mif.ready_mem}, 64'd1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("rl_no_retire", {63'd0, retire}, 64'd0);
        check("rl_no_write", {63'd0, reg_write_en}, 64'd0);
        check("rl_instret", instret, 64'd0);
        check("rl_ready", {63'd0, mif.ready_mem}, 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            issue(mk_instr(17'($urandom), 3'($urandom), 5'($urandom), OP_ALU),
                  $urandom, $urandom, sel, 1'($urandom), $urandom, $urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
